window_3x3_gen: RTL and testbench

//  Builds a 3x3 pixel neighbourhood from a raster-order pixel stream, feeding the

---
 rtl/window_3x3_gen.sv | 93 +++++++++
 tb/tb_window_3x3_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator: two line buffers feed a 3-column shift window
// built from a raster-order pixel stream; only interior windows are flagged valid.
module window_3x3_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CNT_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sof,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic [DATA_WIDTH-1:0] w1,
  output logic [DATA_WIDTH-1:0] w2,
  output logic [DATA_WIDTH-1:0] w3,
  output logic [DATA_WIDTH-1:0] w4,
  output logic [DATA_WIDTH-1:0] w5,
  output logic [DATA_WIDTH-1:0] w6,
  output logic [DATA_WIDTH-1:0] w7,
  output logic [DATA_WIDTH-1:0] w8,
  output logic [DATA_WIDTH-1:0] w9,
  output logic                  win_valid,
  output logic                  frame_done
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] MIN_POS  = CNT_W'(2);

  logic [CNT_W-1:0]      col, row;
  logic [CNT_W-1:0]      cur_col, cur_row;
  logic [DATA_WIDTH-1:0] lb_a [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb_b [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] top, mid;
  logic                  at_last_col, at_last_row;

  // sof forces the accepted pixel to (0,0) regardless of where the counters are
  always_comb begin
    cur_col     = sof ? '0 : col;
    cur_row     = sof ? '0 : row;
    top         = lb_b[cur_col];
    mid         = lb_a[cur_col];
    at_last_col = (cur_col == COL_LAST);
    at_last_row = (cur_row == ROW_LAST);
  end

  // Line-buffer RAM is deliberately unreset; stale rows are masked by row gating
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb_b[cur_col] <= lb_a[cur_col];
      lb_a[cur_col] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (at_last_col) begin
        col <= '0;
        row <= at_last_row ? '0 : cur_row + CNT_W'(1);
      end else begin
        col <= cur_col + CNT_W'(1);
        row <= cur_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w1 <= '0; w2 <= '0; w3 <= '0;
      w4 <= '0; w5 <= '0; w6 <= '0;
      w7 <= '0; w8 <= '0; w9 <= '0;
    end else if (pix_valid) begin
      w1 <= w2;  w4 <= w5;  w7 <= w8;
      w2 <= w3;  w5 <= w6;  w8 <= w9;
      w3 <= top; w6 <= mid; w9 <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= pix_valid && (cur_row >= MIN_POS) && (cur_col >= MIN_POS);
      frame_done <= pix_valid && at_last_row && at_last_col;
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on an 8x6 image: a frame-array model predicts every
// output cycle, plus literal tap values at key pixel positions.
module tb_window_3x3_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sof = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_in = 8'h00;
  logic [7:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
  logic       win_valid, frame_done;

  window_3x3_gen #(
    .DATA_WIDTH(8),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .CNT_W     (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sof       (sof),
    .pix_valid (pix_valid),
    .pix_in    (pix_in),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .w4        (w4),
    .w5        (w5),
    .w6        (w6),
    .w7        (w7),
    .w8        (w8),
    .w9        (w9),
    .win_valid (win_valid),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int win_cnt = 0;
  int fd_cnt = 0;
  bit chk_en = 1'b0;

  // Model: the pixels of the current frame by (row, col) and the expected outputs
  logic [7:0] img [H][W];
  int         mr = 0;
  int         mc = 0;
  bit         exp_valid = 1'b0;
  bit         exp_fd = 1'b0;
  logic [7:0] exp_w [9];
  logic [7:0] taps [9];

  always_comb taps = '{w1, w2, w3, w4, w5, w6, w7, w8, w9};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one input cycle and predict the outputs that follow its clock edge
  task automatic send(input bit v, input bit s, input logic [7:0] p);
    @(negedge clk);
    pix_valid = v;
    sof       = s;
    pix_in    = p;
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = p;
      if (mr >= 2 && mc >= 2) begin
        exp_valid = 1'b1;
        for (int k = 0; k < 9; k++) exp_w[k] = img[mr - 2 + k / 3][mc - 2 + k % 3];
      end
      exp_fd = (mr == H - 1) && (mc == W - 1);
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("win_valid", int'(win_valid), int'(exp_valid));
      chk("frame_done", int'(frame_done), int'(exp_fd));
      if (exp_valid) begin
        for (int k = 0; k < 9; k++) chk($sformatf("w%0d", k + 1), int'(taps[k]), int'(exp_w[k]));
      end
      if (win_valid) win_cnt++;
      if (frame_done) fd_cnt++;
    end
  end

  task automatic lit_check(input int r, input int c);
    if (r == 2 && c == 2) begin
      chk("lit22_valid", int'(win_valid), 1);
      chk("lit22_w1", int'(w1), 'h00);
      chk("lit22_w2", int'(w2), 'h01);
      chk("lit22_w3", int'(w3), 'h02);
      chk("lit22_w5", int'(w5), 'h11);
      chk("lit22_w9", int'(w9), 'h22);
    end else if (r == 3 && c < 2) begin
      chk($sformatf("lit3%0d_valid", c), int'(win_valid), 0);
    end else if (r == 3 && c == 2) begin
      chk("lit32_valid", int'(win_valid), 1);
      chk("lit32_w1", int'(w1), 'h10);
      chk("lit32_w9", int'(w9), 'h32);
    end else if (r == 5 && c == 7) begin
      chk("lit57_valid", int'(win_valid), 1);
      chk("lit57_w1", int'(w1), 'h35);
      chk("lit57_w5", int'(w5), 'h46);
      chk("lit57_w9", int'(w9), 'h57);
      chk("lit57_frame_done", int'(frame_done), 1);
    end
  endtask

  // npix pixels of a frame starting with sof; pixel value base + row*16 + col
  task automatic send_frame(input bit toggle, input int base, input int npix);
    for (int i = 0; i < npix; i++) begin
      int r = i / W;
      int c = i % W;
      send(1'b1, i == 0, 8'(base + r * 16 + c));
      if (i == 0) begin
        win_cnt = 0;
        fd_cnt  = 0;
      end
      if (base == 0 && ((r == 2 && c == 2) || (r == 3 && c <= 2) || (r == 5 && c == 7))) begin
        @(posedge clk);
        #2;
        lit_check(r, c);
      end
      if (toggle) send(1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic flush_and_count(input string tag);
    send(1'b0, 1'b0, 8'h00);
    send(1'b0, 1'b0, 8'h00);
    chk({tag, "_windows"}, win_cnt, (W - 2) * (H - 2));
    chk({tag, "_frame_done_pulses"}, fd_cnt, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset_win_valid", int'(win_valid), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    for (int k = 0; k < 9; k++) chk($sformatf("reset_w%0d", k + 1), int'(taps[k]), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Continuous frame
    send_frame(1'b0, 0, W * H);
    flush_and_count("frame1");

    // pix_valid alternating 1,0
    send_frame(1'b1, 0, W * H);
    flush_and_count("toggle");

    // Frame aborted by sof at (3,4), distinct pixel values, then a clean frame
    send_frame(1'b0, 'h80, 3 * W + 4);
    @(posedge clk);
    #2;
    chk("abort_no_frame_done", fd_cnt, 0);
    send_frame(1'b0, 0, W * H);
    flush_and_count("after_abort");

    // Asynchronous reset mid-row 3
    send_frame(1'b0, 0, 3 * W + 4);
    @(posedge clk);
    #2;
    chk("pre_reset_win_valid", int'(win_valid), 1);
    chk_en    = 1'b0;
    pix_valid = 1'b0;
    sof       = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("async_win_valid", int'(win_valid), 0);
    for (int k = 0; k < 9; k++) chk($sformatf("async_w%0d", k + 1), int'(taps[k]), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    mr        = 0;
    mc        = 0;
    exp_valid = 1'b0;
    exp_fd    = 1'b0;
    chk_en    = 1'b1;
    send_frame(1'b0, 0, W * H);
    flush_and_count("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
